// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: drives the shared ALU for one op at a time,
// runs an iterative MULTU into HI/LO, and returns results on a valid/ready port.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [5:0]   req_opcode,
    input  logic [5:0]   req_funct,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [W-1:0] alu_input1,
    output logic [W-1:0] alu_input2,
    output logic [5:0]   alu_op,
    output logic [5:0]   alu_func,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_wr_file,
    output logic         rsp_err
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
    typedef enum logic [2:0] {K_ALU, K_MUL, K_MFHI, K_MFLO, K_ERR} kind_t;

    state_t         state, state_nxt;
    kind_t          dec_kind;
    logic           dec_wr;
    logic           accept;
    logic           cnt_last;
    logic [5:0]     cnt;
    logic [5:0]     op_q, funct_q;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   hi, lo;
    logic [2*W-1:0] mcand, acc, acc_nxt;
    logic [W-1:0]   mplier;
    logic [W-1:0]   res_q;
    logic           zero_q, wr_q, err_q;

    assign accept   = req_valid & req_ready;
    assign cnt_last = (cnt == 6'd1);
    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        dec_kind = K_ERR;
        dec_wr   = 1'b0;
        case (req_opcode)
            OP_RTYPE: begin
                case (req_funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                        dec_kind = K_ALU;
                        dec_wr   = 1'b1;
                    end
                    FN_MULTU: dec_kind = K_MUL;
                    FN_MFHI: begin
                        dec_kind = K_MFHI;
                        dec_wr   = 1'b1;
                    end
                    FN_MFLO: begin
                        dec_kind = K_MFLO;
                        dec_wr   = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_LB, OP_LW: begin
                dec_kind = K_ALU;
                dec_wr   = 1'b1;
            end
            OP_SW, OP_BEQ: dec_kind = K_ALU;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                case (dec_kind)
                    K_ALU:   state_nxt = EXEC;
                    K_MUL:   state_nxt = MUL;
                    default: state_nxt = RESP;
                endcase
            end
            EXEC:    if (cnt_last) state_nxt = RESP;
            MUL:     if (cnt_last) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath is frozen on flush, so an aborted MULTU never reaches HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_q    <= '0;
            funct_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi      <= '0;
            lo      <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (!flush) begin
            case (state)
                IDLE: if (accept) begin
                    op_q    <= req_opcode;
                    funct_q <= req_funct;
                    a_q     <= req_a;
                    b_q     <= req_b;
                    wr_q    <= dec_wr;
                    err_q   <= (dec_kind == K_ERR);
                    res_q   <= '0;
                    zero_q  <= 1'b0;
                    case (dec_kind)
                        K_ALU: cnt <= 6'(ALU_LAT);
                        K_MUL: begin
                            cnt    <= 6'd32;
                            mcand  <= {{W{1'b0}}, req_b};
                            mplier <= req_a;
                            acc    <= '0;
                        end
                        K_MFHI: begin
                            res_q  <= hi;
                            zero_q <= (hi == '0);
                        end
                        K_MFLO: begin
                            res_q  <= lo;
                            zero_q <= (lo == '0);
                        end
                        default: ;
                    endcase
                end
                EXEC: begin
                    cnt <= cnt - 6'd1;
                    if (cnt_last) begin
                        res_q  <= alu_result;
                        zero_q <= alu_zero;
                    end
                end
                MUL: begin
                    cnt    <= cnt - 6'd1;
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt_last) {hi, lo} <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (state == IDLE);
    assign alu_input1  = (state == EXEC) ? a_q : '0;
    assign alu_input2  = (state == EXEC) ? b_q : '0;
    assign alu_op      = (state == EXEC) ? op_q : '0;
    assign alu_func    = (state == EXEC) ? funct_q : '0;
    assign rsp_valid   = (state == RESP);
    assign rsp_result  = rsp_valid ? res_q : '0;
    assign rsp_zero    = rsp_valid & zero_q;
    assign rsp_wr_file = rsp_valid & wr_q;
    assign rsp_err     = rsp_valid & err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a transaction-level model predicts every visible
// output each cycle; directed scenarios pin the model with literal expectations.
module tb_alu_issue_ctrl;

    localparam int ALU_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [5:0]  req_opcode = '0;
    logic [5:0]  req_funct = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, rsp_valid, rsp_zero, rsp_wr_file, rsp_err, alu_zero;
    logic [31:0] alu_input1, alu_input2, alu_result, rsp_result;
    logic [5:0]  alu_op, alu_func;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_op(alu_op), .alu_func(alu_func),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_wr_file(rsp_wr_file), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // External ALU the controller drives.
    function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [5:0] fn,
                                           input logic [31:0] x, input logic [31:0] y);
        alu_fn = '0;
        if (op == 6'b000000) begin
            case (fn)
                6'b100000: alu_fn = x + y;
                6'b100010: alu_fn = x - y;
                6'b100100: alu_fn = x & y;
                6'b100101: alu_fn = x | y;
                6'b101010: alu_fn = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                default:   alu_fn = '0;
            endcase
        end else begin
            case (op)
                6'b100000, 6'b100011, 6'b101011: alu_fn = x + y;
                6'b000100:                       alu_fn = x - y;
                default:                         alu_fn = '0;
            endcase
        end
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_op, alu_func, alu_input1, alu_input2);
        alu_zero   = (alu_result == 32'd0);
    end

    // kind: 0 ALU, 1 MULTU, 2 MFHI, 3 MFLO, 4 unsupported
    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        kind_of = 4;
        if (op == 6'b000000) begin
            if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) kind_of = 0;
            else if (fn == 6'b011001) kind_of = 1;
            else if (fn == 6'b010000) kind_of = 2;
            else if (fn == 6'b010010) kind_of = 3;
        end else if (op inside {6'b100000, 6'b100011, 6'b101011, 6'b000100}) begin
            kind_of = 0;
        end
    endfunction

    function automatic bit wr_of(input logic [5:0] op, input logic [5:0] fn);
        int k;
        k = kind_of(op, fn);
        wr_of = (k == 2) || (k == 3) || (k == 0 && op != 6'b101011 && op != 6'b000100);
    endfunction

    // Model: one pending transaction with the edge index at which its response appears.
    int          cyc = 0;
    int          ready_at = 0;
    int          e_kind = 0;
    bit          pend = 1'b0;
    bit          e_zero, e_wr, e_err;
    logic [5:0]  e_op = '0, e_fn = '0;
    logic [31:0] e_a = '0, e_b = '0, e_res = '0;
    bit   [63:0] e_prod;
    bit   [31:0] m_hi = '0, m_lo = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc  = 0;
            pend = 1'b0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            cyc++;
            if (flush) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cyc - 1 >= ready_at && rsp_ready) pend = 1'b0;
                else if (cyc == ready_at && e_kind == 1) {m_hi, m_lo} = e_prod;
            end else if (req_valid) begin
                e_kind = kind_of(req_opcode, req_funct);
                e_op   = req_opcode;
                e_fn   = req_funct;
                e_a    = req_a;
                e_b    = req_b;
                e_wr   = wr_of(req_opcode, req_funct);
                e_err  = (e_kind == 4);
                e_prod = {32'd0, req_a} * {32'd0, req_b};
                e_res  = '0;
                e_zero = 1'b0;
                ready_at = cyc;
                case (e_kind)
                    0: begin
                        ready_at = cyc + ALU_LAT;
                        e_res    = alu_fn(req_opcode, req_funct, req_a, req_b);
                        e_zero   = (e_res == 32'd0);
                    end
                    1: ready_at = cyc + 32;
                    2: begin e_res = m_hi; e_zero = (m_hi == 32'd0); end
                    3: begin e_res = m_lo; e_zero = (m_lo == 32'd0); end
                    default: ;
                endcase
                pend = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        bit ev, ex;
        ev = pend && (cyc >= ready_at);
        ex = pend && (e_kind == 0) && (cyc < ready_at);
        check("m_req_ready", 64'(req_ready), 64'(!pend));
        check("m_rsp_valid", 64'(rsp_valid), 64'(ev));
        check("m_alu_input1", 64'(alu_input1), ex ? 64'(e_a) : 64'd0);
        check("m_alu_input2", 64'(alu_input2), ex ? 64'(e_b) : 64'd0);
        check("m_alu_op", 64'(alu_op), ex ? 64'(e_op) : 64'd0);
        check("m_alu_func", 64'(alu_func), ex ? 64'(e_fn) : 64'd0);
        if (ev) begin
            check("m_rsp_result", 64'(rsp_result), 64'(e_res));
            check("m_rsp_zero", 64'(rsp_zero), 64'(e_zero));
            check("m_rsp_wr_file", 64'(rsp_wr_file), 64'(e_wr));
            check("m_rsp_err", 64'(rsp_err), 64'(e_err));
        end
        if (!rst_n) begin
            check("m_rst_result", 64'(rsp_result), 64'd0);
            check("m_rst_flags", 64'({rsp_zero, rsp_wr_file, rsp_err}), 64'd0);
        end
    end

    // Called at a negedge; returns at the first negedge after the accepting edge.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        req_valid  = 1'b1;
        req_opcode = op;
        req_funct  = fn;
        req_a      = a;
        req_b      = b;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int k);
        k = 0;
        while (!rsp_valid && k < max) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_op(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input int lat,
                         input logic [31:0] res, input bit zero, input bit wr, input bit err);
        int k;
        issue(op, fn, a, b);
        wait_rsp(40, k);
        check({name, "_latency"}, 64'(k), 64'(lat));
        check({name, "_valid"}, 64'(rsp_valid), 64'd1);
        check({name, "_result"}, 64'(rsp_result), 64'(res));
        check({name, "_zero"}, 64'(rsp_zero), 64'(zero));
        check({name, "_wr_file"}, 64'(rsp_wr_file), 64'(wr));
        check({name, "_err"}, 64'(rsp_err), 64'(err));
        @(negedge clk);
        check({name, "_released"}, 64'({rsp_valid, req_ready}), 64'b01);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_alu_outs", 64'({alu_input1, alu_op, alu_func}), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // add 100+99: response visible after edge E0+1, handshake at E0+2
        issue(6'b000000, 6'b100000, 32'd100, 32'd99);
        check("add_exec_in1", 64'(alu_input1), 64'd100);
        check("add_exec_in2", 64'(alu_input2), 64'd99);
        check("add_not_yet_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("add_valid", 64'(rsp_valid), 64'd1);
        check("add_result", 64'(rsp_result), 64'd199);
        check("add_flags", 64'({rsp_zero, rsp_wr_file, rsp_err}), 64'b010);
        @(negedge clk);
        check("add_released", 64'({rsp_valid, req_ready}), 64'b01);

        // sub 99-99 held 5 cycles with rsp_ready low
        rsp_ready = 1'b0;
        issue(6'b000000, 6'b100010, 32'd99, 32'd99);
        wait_rsp(10, k);
        for (int i = 0; i < 5; i++) begin
            check("sub_hold_valid", 64'(rsp_valid), 64'd1);
            check("sub_hold_result", 64'(rsp_result), 64'd0);
            check("sub_hold_zero", 64'(rsp_zero), 64'd1);
            check("sub_hold_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("sub_released", 64'({rsp_valid, req_ready}), 64'b01);

        // MULTU 0xFFFFFFFF*2 then read back
        do_op("multu_big", 6'b000000, 6'b011001, 32'hFFFF_FFFF, 32'd2, 32, 32'd0, 1'b0, 1'b0, 1'b0);
        do_op("mfhi_big", 6'b000000, 6'b010000, 32'd0, 32'd0, 0, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        do_op("mflo_big", 6'b000000, 6'b010010, 32'd0, 32'd0, 0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);

        // error and other supported ops
        do_op("bad_opcode", 6'b111111, 6'b100000, 32'd100, 32'd99, 0, 32'd0, 1'b0, 1'b0, 1'b1);
        do_op("bad_funct", 6'b000000, 6'b100111, 32'd1, 32'd2, 0, 32'd0, 1'b0, 1'b0, 1'b1);
        do_op("sw", 6'b101011, 6'b000000, 32'd100, 32'd99, ALU_LAT, 32'd199, 1'b0, 1'b0, 1'b0);
        do_op("beq_eq", 6'b000100, 6'b000000, 32'd5, 32'd5, ALU_LAT, 32'd0, 1'b1, 1'b0, 1'b0);
        do_op("lw", 6'b100011, 6'b000000, 32'd8, 32'd4, ALU_LAT, 32'd12, 1'b0, 1'b1, 1'b0);
        do_op("lb", 6'b100000, 6'b000000, 32'h10, 32'hFFFF_FFFC, ALU_LAT, 32'hC, 1'b0, 1'b1, 1'b0);
        do_op("and", 6'b000000, 6'b100100, 32'hF0F0, 32'hFF00, ALU_LAT, 32'hF000, 1'b0, 1'b1, 1'b0);
        do_op("or", 6'b000000, 6'b100101, 32'hF0F0, 32'hFF00, ALU_LAT, 32'hFFF0, 1'b0, 1'b1, 1'b0);
        do_op("slt_neg", 6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, ALU_LAT, 32'd1, 1'b0, 1'b1, 1'b0);

        // flush at cycle 10 of MULTU 5*7 with HI=0, LO=3 beforehand
        do_op("multu_1x3", 6'b000000, 6'b011001, 32'd1, 32'd3, 32, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(6'b000000, 6'b011001, 32'd5, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", 64'(req_ready), 64'd1);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) k++;
            @(negedge clk);
        end
        check("flush_no_rsp", 64'(k), 64'd0);
        do_op("mflo_after_flush", 6'b000000, 6'b010010, 32'd0, 32'd0, 0, 32'd3, 1'b0, 1'b1, 1'b0);
        do_op("mfhi_after_flush", 6'b000000, 6'b010000, 32'd0, 32'd0, 0, 32'd0, 1'b1, 1'b1, 1'b0);

        // reset during EXEC clears HI/LO and idles immediately
        do_op("multu_5x7", 6'b000000, 6'b011001, 32'd5, 32'd7, 32, 32'd0, 1'b0, 1'b0, 1'b0);
        do_op("mflo_35", 6'b000000, 6'b010010, 32'd0, 32'd0, 0, 32'd35, 1'b0, 1'b1, 1'b0);
        issue(6'b000000, 6'b100000, 32'd1, 32'd2);
        check("pre_reset_exec", 64'(alu_input1), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midop_reset_ready", 64'(req_ready), 64'd1);
        check("midop_reset_valid", 64'(rsp_valid), 64'd0);
        check("midop_reset_alu", 64'({alu_input1, alu_input2, alu_op, alu_func}), 64'd0);
        check("midop_reset_rsp", 64'({rsp_result, rsp_zero, rsp_wr_file, rsp_err}), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        do_op("mfhi_after_rst", 6'b000000, 6'b010000, 32'd0, 32'd0, 0, 32'd0, 1'b1, 1'b1, 1'b0);
        do_op("mflo_after_rst", 6'b000000, 6'b010010, 32'd0, 32'd0, 0, 32'd0, 1'b1, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
